hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Sits opposite the F/D, D/E and E/M pipeline registers and drives their stall/flush inputs: stallF, stallD, stallE, flushD, flushE.
- Also supplies EX-stage forwarding selects.
- Tracks the multi-cycle divider in EX with an internal busy FSM and counter, so the ID/EX register holds the divide for its full latency.

Parameters:
- DIV_CYCLES, 32: total stall cycles for one divide in EX; legal range 2..255.
- CNT_W, 8: width of the divide counter; must satisfy 2^CNT_W > DIV_CYCLES.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rsD, rtD  in  5  source registers of the instruction in ID.
- rsE, rtE  in  5  source registers of the instruction in EX.
- writeregE, writeregM, writeregW  in  5  destination register per stage.
- regwriteE, regwriteM, regwriteW  in  1  register-write enable per stage.
- memtoregE  in  2  nonzero means the instruction in EX is a load.
- mispredictE  in  1  branch/jump resolved wrong in EX.
- div_startE  in  1  divide instruction present in EX; level, held while stalled.
- stallF, stallD, stallE  out  1  hold the PC, F/D and D/E registers.
- flushD, flushE  out  1  clear the F/D and D/E registers.
- forwardAE, forwardBE  out  2  00 = regfile, 01 = W result, 10 = M result.
- div_readyE  out  1  divide result valid this cycle.

Behaviour:
- Reset (rst=0, async): FSM goes to IDLE and cnt to 0. While rst=0, every output is forced to 0. A reset mid-divide abandons the divide; no div_readyE pulse follows.
- Forwarding (combinational):
  - forwardAE=10 if regwriteM && writeregM!=0 && writeregM==rsE.
  - Else forwardAE=01 if regwriteW && writeregW!=0 && writeregW==rsE.
  - Else forwardAE=00.
  - forwardBE is identical using rtE.
  - M has priority over W. Register $0 is never forwarded.
- lwstall = (memtoregE!=0) && regwriteE && writeregE!=0 && (writeregE==rsD || writeregE==rtD).
- Divider FSM, states IDLE and BUSY:
  - IDLE with div_startE=1: next state BUSY, cnt <= DIV_CYCLES-1. divstall=1 in this cycle.
  - BUSY with cnt!=0: divstall=1, cnt decrements.
  - BUSY with cnt==0: divstall=0, div_readyE=1, next state IDLE. div_startE is ignored in this cycle, because the same divide is still present.
  - Total stall is exactly DIV_CYCLES cycles. div_readyE is a single-cycle pulse in cycle DIV_CYCLES+1, counting the start cycle as cycle 1.
- Output priority (combinational from state and inputs), first match wins:
  - 1. divstall: stallF=stallD=stallE=1, flushD=flushE=0.
  - 2. mispredictE: flushD=flushE=1, all stalls 0. This overrides lwstall.
  - 3. lwstall: stallF=stallD=1, stallE=0, flushE=1 (bubble inserted), flushD=0.
  - 4. Otherwise all stall/flush outputs are 0.
- mispredictE and div_startE must not be high together; if they are, divstall wins and mispredictE is held off until the stall releases.
- Back-to-back divides: a new div_startE in the IDLE cycle immediately after a completion starts a fresh DIV_CYCLES stall.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs stall_cycles [31:0] and flush_events [31:0].
  - stall_cycles increments on each cycle with stallF=1.
  - flush_events increments on each cycle with mispredictE-driven flushD=1.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Forwarding priority:
  - regwriteM=1, writeregM=5, regwriteW=1, writeregW=5, rsE=5 -> forwardAE=10.
  - Then drop regwriteM -> forwardAE=01.
  - writeregM=0, rsE=0 -> forwardAE=00.
- Load-use: memtoregE=01, regwriteE=1, writeregE=8, rtD=8 -> stallF=stallD=1, flushE=1, stallE=0 for exactly one cycle once the load advances.
- Divide, DIV_CYCLES=4: hold div_startE=1 -> stallE=1 for 4 cycles, then div_readyE=1 for exactly 1 cycle with stalls 0, then back to IDLE.
- Mispredict vs lwstall: mispredictE=1 with lwstall conditions true -> flushD=flushE=1, stallF=0.
- Reset mid-divide: assert rst=0 at BUSY cnt=2 -> outputs go to 0 immediately; after release with div_startE=0, div_readyE never pulses.
- HAZARD_PERF_EN: run the 4-cycle divide plus one mispredict -> stall_cycles=4, flush_events=1.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Purpose: bundles every hazard_ctrl signal except clk/rst; master = pipeline side, slave = hazard_ctrl.
// Latency: none, the interface is plain wiring.
// Backpressure: stall/flush lines carry the pipeline's only flow control; there is no valid/ready.
// Ports: ID/EX/MEM/WB register ids and write enables in; stall, flush, forward selects and div_readyE out.
// Macro HAZARD_PERF_EN adds the stall_cycles / flush_events counter outputs.
interface hazard_ctrl_if;
  logic [4:0] rsD;
  logic [4:0] rtD;
  logic [4:0] rsE;
  logic [4:0] rtE;
  logic [4:0] writeregE;
  logic [4:0] writeregM;
  logic [4:0] writeregW;
  logic       regwriteE;
  logic       regwriteM;
  logic       regwriteW;
  logic [1:0] memtoregE;
  logic       mispredictE;
  logic       div_startE;
  logic       stallF;
  logic       stallD;
  logic       stallE;
  logic       flushD;
  logic       flushE;
  logic [1:0] forwardAE;
  logic [1:0] forwardBE;
  logic       div_readyE;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    output regwriteE, regwriteM, regwriteW, memtoregE, mispredictE, div_startE,
    input  stallF, stallD, stallE, flushD, flushE, forwardAE, forwardBE, div_readyE,
    input  stall_cycles, flush_events
  );
  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    input  regwriteE, regwriteM, regwriteW, memtoregE, mispredictE, div_startE,
    output stallF, stallD, stallE, flushD, flushE, forwardAE, forwardBE, div_readyE,
    output stall_cycles, flush_events
  );
`else
  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    output regwriteE, regwriteM, regwriteW, memtoregE, mispredictE, div_startE,
    input  stallF, stallD, stallE, flushD, flushE, forwardAE, forwardBE, div_readyE
  );
  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    input  regwriteE, regwriteM, regwriteW, memtoregE, mispredictE, div_startE,
    output stallF, stallD, stallE, flushD, flushE, forwardAE, forwardBE, div_readyE
  );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// Purpose: 5-stage MIPS hazard unit - load-use/divide stalls, mispredict flushes, EX forwarding selects.
// Latency: all outputs combinational from inputs and the divider FSM; a divide stalls DIV_CYCLES cycles.
// Backpressure: divide stall beats mispredict flush beats load-use stall; held instructions must keep inputs stable.
// Ports: clk, rst (async active-low), hif (hazard_ctrl_if.slave) carrying pipeline ids and stall/flush/forward outputs.
// Macro HAZARD_PERF_EN: adds saturating stall_cycles / flush_events counters on hif.
module hazard_ctrl #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 8
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hif
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // The start cycle is the first stall cycle, so BUSY counts down the remaining DIV_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic       divstall;
  logic       div_ready;
  logic       lwstall;
  logic       stall_f;
  logic       stall_d;
  logic       stall_e;
  logic       flush_d;
  logic       flush_e;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  // M beats W; register $0 is hard-wired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       rw_m,
    input logic [4:0] wr_m,
    input logic       rw_w,
    input logic [4:0] wr_w
  );
    if (rw_m && (wr_m != 5'd0) && (wr_m == src))
      return 2'b10;
    else if (rw_w && (wr_w != 5'd0) && (wr_w == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (hif.div_startE) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      BUSY: begin
        // In the completion cycle div_startE still shows the finishing divide, so it is ignored.
        if (cnt != '0)
          cnt_nxt = cnt - CNT_W'(1);
        else
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    divstall  = 1'b0;
    div_ready = 1'b0;
    case (state)
      IDLE: divstall = hif.div_startE;
      BUSY: begin
        if (cnt != '0)
          divstall = 1'b1;
        else
          div_ready = 1'b1;
      end
      default: divstall = 1'b0;
    endcase

    lwstall = (hif.memtoregE != 2'b00) && hif.regwriteE && (hif.writeregE != 5'd0) &&
              ((hif.writeregE == hif.rsD) || (hif.writeregE == hif.rtD));

    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (divstall) begin
      // A mispredict seen during the divide waits: the branch sits behind the stalled D/E stage.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
    end else if (hif.mispredictE) begin
      // The wrong-path instruction in ID is flushed, so its load-use hazard no longer matters.
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lwstall) begin
      // Hold F/D, let the load advance, and push a bubble into EX.
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end

    fwd_a = fwd_sel(hif.rsE, hif.regwriteM, hif.writeregM, hif.regwriteW, hif.writeregW);
    fwd_b = fwd_sel(hif.rtE, hif.regwriteM, hif.writeregM, hif.regwriteW, hif.writeregW);
  end

  // Reset forces every output low, including the purely combinational forwarding selects.
  assign hif.stallF     = rst & stall_f;
  assign hif.stallD     = rst & stall_d;
  assign hif.stallE     = rst & stall_e;
  assign hif.flushD     = rst & flush_d;
  assign hif.flushE     = rst & flush_e;
  assign hif.div_readyE = rst & div_ready;
  assign hif.forwardAE  = rst ? fwd_a : 2'b00;
  assign hif.forwardBE  = rst ? fwd_b : 2'b00;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  // flush_d only comes from the mispredict branch, so it doubles as the mispredict-flush event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (flush_d && (flush_cnt != 32'hFFFF_FFFF))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign hif.stall_cycles = stall_cnt;
  assign hif.flush_events = flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: scoreboard bench for hazard_ctrl with directed cases plus random traffic against a reference model.
// Latency: expected outputs are queued when inputs are applied and compared on the following falling edge.
// Backpressure: none; the monitor pops one expectation per cycle while the queue holds entries.
module tb_hazard_ctrl;

  localparam int DIV = 4;

  typedef struct packed {
    logic       rst;
    logic [4:0] rsD;
    logic [4:0] rtD;
    logic [4:0] rsE;
    logic [4:0] rtE;
    logic [4:0] wE;
    logic [4:0] wM;
    logic [4:0] wW;
    logic       rwE;
    logic       rwM;
    logic       rwW;
    logic [1:0] mem;
    logic       mp;
    logic       start;
  } stim_t;

  typedef struct packed {
    logic [9:0]  outs;
    logic [31:0] sc;
    logic [31:0] fe;
  } exp_t;

  logic clk;
  logic rst;
  hazard_ctrl_if hif();

  hazard_ctrl #(.DIV_CYCLES(DIV), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t  sb_q[$];
  exp_t  mon_e;
  logic [9:0] mon_got;
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model: cycles of the current divide already completed (0 = no divide in flight).
  int          age = 0;
  logic [31:0] sc_ref = '0;
  logic [31:0] fe_ref = '0;
  stim_t       prev_s = '0;
  exp_t        prev_e = '0;

  function automatic logic [1:0] fwd_ref(input logic [4:0] src, input stim_t s);
    if (s.rwM && s.wM != 0 && s.wM == src) return 2'b10;
    if (s.rwW && s.wW != 0 && s.wW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t expect_of(input stim_t s);
    exp_t e;
    logic div_st, rdy, lw;
    logic sf, sd, se, fd, fl;
    e = '0;
    e.sc = sc_ref;
    e.fe = fe_ref;
    if (!s.rst) return e;
    // Divide occupies DIV stall cycles starting with the cycle div_startE first appears, then one ready cycle.
    div_st = (age == 0 && s.start) || (age >= 1 && age < DIV);
    rdy    = (age == DIV);
    lw = (s.mem != 0) && s.rwE && (s.wE != 0) && (s.wE == s.rsD || s.wE == s.rtD);
    {sf, sd, se, fd, fl} = 5'b00000;
    if (div_st)    {sf, sd, se, fd, fl} = 5'b11100;
    else if (s.mp) {sf, sd, se, fd, fl} = 5'b00011;
    else if (lw)   {sf, sd, se, fd, fl} = 5'b11001;
    e.outs = {sf, sd, se, fd, fl, fwd_ref(s.rsE, s), fwd_ref(s.rtE, s), rdy};
    return e;
  endfunction

  task automatic drive(input stim_t s_in, input bit rnd_start);
    stim_t s;
    exp_t  e;
    s = s_in;
    @(posedge clk);
    if (prev_s.rst) begin
      if (prev_e.outs[9] && sc_ref != 32'hFFFF_FFFF) sc_ref = sc_ref + 1;
      if (prev_e.outs[6] && fe_ref != 32'hFFFF_FFFF) fe_ref = fe_ref + 1;
      if (age == DIV) age = 0;
      else if (age > 0 || prev_s.start) age = age + 1;
    end
    if (rnd_start) begin
      // A divide stays present in EX (level) until its ready cycle.
      if (age >= 1 && age < DIV) s.start = 1'b1;
      else if (age == DIV)       s.start = 1'($urandom_range(0, 1));
      else                       s.start = ($urandom_range(0, 5) == 0);
    end
    #1;
    rst           = s.rst;
    hif.rsD       = s.rsD;
    hif.rtD       = s.rtD;
    hif.rsE       = s.rsE;
    hif.rtE       = s.rtE;
    hif.writeregE = s.wE;
    hif.writeregM = s.wM;
    hif.writeregW = s.wW;
    hif.regwriteE = s.rwE;
    hif.regwriteM = s.rwM;
    hif.regwriteW = s.rwW;
    hif.memtoregE = s.mem;
    hif.mispredictE = s.mp;
    hif.div_startE  = s.start;
    if (!s.rst) begin
      age    = 0;
      sc_ref = '0;
      fe_ref = '0;
    end
    e = expect_of(s);
    sb_q.push_back(e);
    prev_s = s;
    prev_e = e;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst = ($urandom_range(0, 59) != 0);
    s.rsD = 5'($urandom_range(0, 3));
    s.rtD = 5'($urandom_range(0, 3));
    s.rsE = 5'($urandom_range(0, 3));
    s.rtE = 5'($urandom_range(0, 3));
    s.wE  = 5'($urandom_range(0, 3));
    s.wM  = 5'($urandom_range(0, 3));
    s.wW  = 5'($urandom_range(0, 3));
    s.rwE = 1'($urandom_range(0, 1));
    s.rwM = 1'($urandom_range(0, 1));
    s.rwW = 1'($urandom_range(0, 1));
    s.mem = 2'($urandom_range(0, 3));
    s.mp  = ($urandom_range(0, 7) == 0);
    s.start = 1'b0;
    return s;
  endfunction

  // Monitor: one queued expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e   = sb_q.pop_front();
      mon_got = {hif.stallF, hif.stallD, hif.stallE, hif.flushD, hif.flushE,
                 hif.forwardAE, hif.forwardBE, hif.div_readyE};
      n_cmp++;
      if (mon_got !== mon_e.outs) begin
        n_bad++;
        $display("FAIL outputs t=%0t {sF,sD,sE,fD,fE,fA,fB,rdy} got=%b exp=%b", $time, mon_got, mon_e.outs);
      end
`ifdef HAZARD_PERF_EN
      n_cmp++;
      if (hif.stall_cycles !== mon_e.sc || hif.flush_events !== mon_e.fe) begin
        n_bad++;
        $display("FAIL perf_counters t=%0t got sc=%0d fe=%0d exp sc=%0d fe=%0d",
                 $time, hif.stall_cycles, hif.flush_events, mon_e.sc, mon_e.fe);
      end
`endif
    end
  end

  initial begin
    stim_t s;
    rst = 1'b0;
    hif.rsD = '0; hif.rtD = '0; hif.rsE = '0; hif.rtE = '0;
    hif.writeregE = '0; hif.writeregM = '0; hif.writeregW = '0;
    hif.regwriteE = 1'b0; hif.regwriteM = 1'b0; hif.regwriteW = 1'b0;
    hif.memtoregE = '0; hif.mispredictE = 1'b0; hif.div_startE = 1'b0;

    // Reset state, with forwarding conditions present to show they are masked.
    s = '0; s.rwM = 1'b1; s.wM = 5'd5; s.rsE = 5'd5;
    drive(s, 1'b0);
    drive(s, 1'b0);

    // Forwarding priority: M over W, then W, then $0 never forwarded.
    s = '0; s.rst = 1'b1; s.rwM = 1'b1; s.wM = 5'd5; s.rwW = 1'b1; s.wW = 5'd5; s.rsE = 5'd5; s.rtE = 5'd5;
    drive(s, 1'b0);
    s.rwM = 1'b0;
    drive(s, 1'b0);
    s.rwM = 1'b1; s.wM = 5'd0; s.rsE = 5'd0; s.rtE = 5'd0;
    drive(s, 1'b0);

    // Load-use on rtD for one cycle, then the load has moved on.
    s = '0; s.rst = 1'b1; s.mem = 2'b01; s.rwE = 1'b1; s.wE = 5'd8; s.rtD = 5'd8;
    drive(s, 1'b0);
    s.mem = 2'b00; s.rwE = 1'b0; s.wE = 5'd0;
    drive(s, 1'b0);

    // Divide held through its stall and ready cycles, then idle.
    s = '0; s.rst = 1'b1; s.start = 1'b1;
    repeat (DIV + 1) drive(s, 1'b0);
    s.start = 1'b0;
    repeat (2) drive(s, 1'b0);

    // Mispredict overrides a live load-use hazard.
    s = '0; s.rst = 1'b1; s.mp = 1'b1; s.mem = 2'b10; s.rwE = 1'b1; s.wE = 5'd3; s.rsD = 5'd3;
    drive(s, 1'b0);

    // Back-to-back divides: new start right after the ready cycle.
    s = '0; s.rst = 1'b1; s.start = 1'b1;
    repeat (2 * (DIV + 1)) drive(s, 1'b0);
    s.start = 1'b0;
    drive(s, 1'b0);

    // Reset while BUSY with cnt=2; no ready pulse may follow.
    s = '0; s.rst = 1'b1; s.start = 1'b1;
    repeat (2) drive(s, 1'b0);
    s.rst = 1'b0; s.start = 1'b0;
    drive(s, 1'b0);
    s.rst = 1'b1;
    repeat (DIV + 3) drive(s, 1'b0);

    // Counter scenario from a clean reset: one 4-cycle divide then one mispredict.
    s.start = 1'b1;
    repeat (DIV + 1) drive(s, 1'b0);
    s.start = 1'b0; s.mp = 1'b1;
    drive(s, 1'b0);
    s.mp = 1'b0;
    repeat (2) drive(s, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) drive(rand_stim(), 1'b1);
    s = '0; s.rst = 1'b1;
    drive(s, 1'b0);

    for (int k = 0; k < 5 && sb_q.size() != 0; k++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain got=%0d pending exp=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
